// File: rtl/sensor_pkg.sv
// Shared types and helpers for the sensor sampling sequencer: FSM state
// encoding, default hysteresis thresholds and the flag update function.
package sensor_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENABLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_PUBLISH = 2'd3
  } sampler_state_t;

  localparam int DEF_SOIL_DRY_ON  = 700;
  localparam int DEF_SOIL_DRY_OFF = 600;
  localparam int DEF_RAIN_ON      = 300;
  localparam int DEF_RAIN_OFF     = 400;

  // Thresholds never overlap, so the order of set/clear only matters for
  // a misconfigured instance; set wins in that case.
  function automatic logic hyst_next(input logic cur, input logic set_c, input logic clr_c);
    if (set_c) return 1'b1;
    if (clr_c) return 1'b0;
    return cur;
  endfunction

endpackage

// File: rtl/sensor_accum.sv
// Per-channel block accumulator; sized so a full block of maximum codes
// cannot overflow, and presents the floor average of the block so far.
module sensor_accum
  import sensor_pkg::*;
#(
  parameter int RESOLUTION = 10,
  parameter int AVG_LOG2   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  add,
  input  logic [RESOLUTION-1:0] din,
  output logic [RESOLUTION-1:0] avg
);

  localparam int AW = RESOLUTION + AVG_LOG2;

  logic [AW-1:0] acc_q, acc_d;

  function automatic logic [RESOLUTION-1:0] avg_floor(input logic [AW-1:0] a);
    return a[AW-1:AVG_LOG2];
  endfunction

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add) begin
      acc_d = acc_q + AW'(din);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign avg = avg_floor(acc_q);

endmodule

// File: rtl/sensor_sampler.sv
// Sampling sequencer: strobes the ADC stage every SAMPLE_DIV cycles,
// averages blocks of 2^AVG_LOG2 captures and derives hysteresis flags.
module sensor_sampler
  import sensor_pkg::*;
#(
  parameter int RESOLUTION   = 10,
  parameter int SAMPLE_DIV   = 1000,
  parameter int AVG_LOG2     = 3,
  parameter int SOIL_DRY_ON  = DEF_SOIL_DRY_ON,
  parameter int SOIL_DRY_OFF = DEF_SOIL_DRY_OFF,
  parameter int RAIN_ON      = DEF_RAIN_ON,
  parameter int RAIN_OFF     = DEF_RAIN_OFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [RESOLUTION-1:0] soil_digital,
  input  logic [RESOLUTION-1:0] dht11_digital,
  input  logic [RESOLUTION-1:0] rain_digital,
  output logic                  sensor_enable,
  output logic [RESOLUTION-1:0] soil_avg,
  output logic [RESOLUTION-1:0] dht11_avg,
  output logic [RESOLUTION-1:0] rain_avg,
  output logic                  avg_valid,
  output logic                  soil_dry,
  output logic                  raining
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int DW = $clog2(SAMPLE_DIV);

  localparam logic [DW-1:0]         DIV_LAST   = DW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0]         CNT_LAST   = CW'(N - 1);
  localparam logic [RESOLUTION-1:0] SOIL_ON_C  = RESOLUTION'(SOIL_DRY_ON);
  localparam logic [RESOLUTION-1:0] SOIL_OFF_C = RESOLUTION'(SOIL_DRY_OFF);
  localparam logic [RESOLUTION-1:0] RAIN_ON_C  = RESOLUTION'(RAIN_ON);
  localparam logic [RESOLUTION-1:0] RAIN_OFF_C = RESOLUTION'(RAIN_OFF);

  sampler_state_t state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           acc_add, acc_clr;

  logic [RESOLUTION-1:0] soil_new, dht11_new, rain_new;
  logic [RESOLUTION-1:0] soil_avg_q, soil_avg_d;
  logic [RESOLUTION-1:0] dht11_avg_q, dht11_avg_d;
  logic [RESOLUTION-1:0] rain_avg_q, rain_avg_d;
  logic                  avg_valid_q, avg_valid_d;
  logic                  soil_dry_q, soil_dry_d;
  logic                  raining_q, raining_d;

  sensor_accum #(.RESOLUTION(RESOLUTION), .AVG_LOG2(AVG_LOG2)) u_soil (
    .clk(clk), .reset(reset), .clr(acc_clr), .add(acc_add),
    .din(soil_digital), .avg(soil_new)
  );

  sensor_accum #(.RESOLUTION(RESOLUTION), .AVG_LOG2(AVG_LOG2)) u_dht11 (
    .clk(clk), .reset(reset), .clr(acc_clr), .add(acc_add),
    .din(dht11_digital), .avg(dht11_new)
  );

  sensor_accum #(.RESOLUTION(RESOLUTION), .AVG_LOG2(AVG_LOG2)) u_rain (
    .clk(clk), .reset(reset), .clr(acc_clr), .add(acc_add),
    .din(rain_digital), .avg(rain_new)
  );

  always_comb begin
    state_d     = state_q;
    div_d       = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    cnt_d       = cnt_q;
    acc_add     = 1'b0;
    acc_clr     = 1'b0;
    soil_avg_d  = soil_avg_q;
    dht11_avg_d = dht11_avg_q;
    rain_avg_d  = rain_avg_q;
    avg_valid_d = 1'b0;
    soil_dry_d  = soil_dry_q;
    raining_d   = raining_q;

    unique case (state_q)
      S_IDLE: begin
        if (!run) begin
          acc_clr = 1'b1;
          cnt_d   = '0;
        end else if (div_q == DIV_LAST) begin
          state_d = S_ENABLE;
        end
      end
      S_ENABLE: begin
        // The ADC converts on this strobe regardless; dropping run only
        // throws the sample away.
        if (run) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_IDLE;
          acc_clr = 1'b1;
          cnt_d   = '0;
        end
      end
      S_CAPTURE: begin
        if (run) begin
          acc_add = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == CNT_LAST) ? S_PUBLISH : S_IDLE;
        end else begin
          state_d = S_IDLE;
          acc_clr = 1'b1;
          cnt_d   = '0;
        end
      end
      S_PUBLISH: begin
        // Completes even with run low so a full block is never lost.
        soil_avg_d  = soil_new;
        dht11_avg_d = dht11_new;
        rain_avg_d  = rain_new;
        soil_dry_d  = hyst_next(soil_dry_q, soil_new >= SOIL_ON_C, soil_new <= SOIL_OFF_C);
        raining_d   = hyst_next(raining_q, rain_new <= RAIN_ON_C, rain_new >= RAIN_OFF_C);
        avg_valid_d = 1'b1;
        acc_clr     = 1'b1;
        cnt_d       = '0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      soil_avg_q  <= '0;
      dht11_avg_q <= '0;
      rain_avg_q  <= '0;
      avg_valid_q <= 1'b0;
      soil_dry_q  <= 1'b0;
      raining_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      soil_avg_q  <= soil_avg_d;
      dht11_avg_q <= dht11_avg_d;
      rain_avg_q  <= rain_avg_d;
      avg_valid_q <= avg_valid_d;
      soil_dry_q  <= soil_dry_d;
      raining_q   <= raining_d;
    end
  end

  assign sensor_enable = (state_q == S_ENABLE);
  assign soil_avg      = soil_avg_q;
  assign dht11_avg     = dht11_avg_q;
  assign rain_avg      = rain_avg_q;
  assign avg_valid     = avg_valid_q;
  assign soil_dry      = soil_dry_q;
  assign raining       = raining_q;

endmodule

// File: tb/tb_sensor_sampler.sv
// Directed bench for sensor_sampler with SAMPLE_DIV=8, AVG_LOG2=2; an ADC
// stand-in feeds queued codes on each strobe and a scoreboard checks publishes.
module tb_sensor_sampler;

  localparam int RES = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic           run;
  logic [RES-1:0] soil_digital, dht11_digital, rain_digital;
  logic           sensor_enable;
  logic [RES-1:0] soil_avg, dht11_avg, rain_avg;
  logic           avg_valid, soil_dry, raining;

  always #5 clk = ~clk;

  sensor_sampler #(.RESOLUTION(RES), .SAMPLE_DIV(8), .AVG_LOG2(2)) dut (
    .clk(clk), .reset(reset), .run(run),
    .soil_digital(soil_digital), .dht11_digital(dht11_digital), .rain_digital(rain_digital),
    .sensor_enable(sensor_enable),
    .soil_avg(soil_avg), .dht11_avg(dht11_avg), .rain_avg(rain_avg),
    .avg_valid(avg_valid), .soil_dry(soil_dry), .raining(raining)
  );

  typedef struct {
    int soil;
    int dht;
    int rain;
    int dry;
    int rn;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   exp_strobe[$];
  int   q_soil[$], q_dht[$], q_rain[$];
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   n_strobe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (sensor_enable) begin
      n_strobe++;
      if (exp_strobe.size() > 0) check("strobe_cycle", cyc, exp_strobe.pop_front());
      if (q_soil.size() > 0) soil_digital = RES'(q_soil.pop_front());
      if (q_dht.size() > 0)  dht11_digital = RES'(q_dht.pop_front());
      if (q_rain.size() > 0) rain_digital = RES'(q_rain.pop_front());
    end
    if (avg_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_avg_valid", avg_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("soil_avg", soil_avg, e.soil);
        check("dht11_avg", dht11_avg, e.dht);
        check("rain_avg", rain_avg, e.rain);
        check("soil_dry", soil_dry, e.dry);
        check("raining", raining, e.rn);
        if (e.cyc >= 0) check("valid_cycle", cyc, e.cyc);
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout_pending", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_sensor_enable"}, sensor_enable, 0);
    check({pfx, "_soil_avg"}, soil_avg, 0);
    check({pfx, "_dht11_avg"}, dht11_avg, 0);
    check({pfx, "_rain_avg"}, rain_avg, 0);
    check({pfx, "_avg_valid"}, avg_valid, 0);
    check({pfx, "_soil_dry"}, soil_dry, 0);
    check({pfx, "_raining"}, raining, 0);
  endtask

  task automatic push_codes(input int s, input int d, input int r, input int n);
    for (int i = 0; i < n; i++) begin
      q_soil.push_back(s);
      q_dht.push_back(d);
      q_rain.push_back(r);
    end
  endtask

  task automatic push_exp(input int s, input int d, input int r, input int dry, input int rn, input int c);
    exp_t e;
    e.soil = s; e.dht = d; e.rain = r; e.dry = dry; e.rn = rn; e.cyc = c;
    exp_q.push_back(e);
  endtask

  initial begin
    int s0;
    int b;
    n_cmp = 0;
    n_err = 0;
    n_strobe = 0;
    cyc = 0;
    reset = 1'b1;
    run = 1'b1;
    soil_digital = 10'd512;
    dht11_digital = 10'd300;
    rain_digital = 10'd1000;

    // Reset state, then a constant-input block
    do_reset();
    check_zero("rst0");
    exp_strobe.push_back(8);
    exp_strobe.push_back(16);
    exp_strobe.push_back(24);
    exp_strobe.push_back(32);
    push_exp(512, 300, 1000, 0, 0, 35);
    drain(60);

    // Truncating average: (100+101+102+103)/4 = 101.5 -> 101
    push_codes(100, 300, 1000, 1);
    push_codes(101, 300, 1000, 1);
    push_codes(102, 300, 1000, 1);
    push_codes(103, 300, 1000, 1);
    push_exp(101, 300, 1000, 0, 0, 67);
    drain(40);

    // Hysteresis on both flags
    push_codes(750, 300, 250, 4);
    push_codes(650, 300, 350, 4);
    push_codes(590, 300, 420, 4);
    push_codes(650, 300, 420, 4);
    push_exp(750, 300, 250, 1, 1, 99);
    push_exp(650, 300, 350, 1, 1, 131);
    push_exp(590, 300, 420, 0, 0, 163);
    push_exp(650, 300, 420, 0, 0, 195);
    drain(200);

    // run dropped after two captures; partial block must be discarded
    push_codes(900, 300, 420, 2);
    push_codes(20, 300, 420, 1);
    push_codes(21, 300, 420, 1);
    push_codes(22, 300, 420, 1);
    push_codes(23, 300, 420, 1);
    s0 = n_strobe;
    b = 0;
    while (n_strobe < s0 + 2 && b < 40) begin
      tick();
      b++;
    end
    check("t4_two_strobes", n_strobe - s0, 2);
    tick();
    tick();
    run = 1'b0;
    repeat (20) tick();
    check("t4_hold_soil_avg", soil_avg, 650);
    check("t4_hold_rain_avg", rain_avg, 420);
    check("t4_no_strobe_while_halted", n_strobe - s0, 2);
    run = 1'b1;
    s0 = n_strobe;
    push_exp(21, 300, 420, 0, 0, -1);
    drain(60);
    check("t4_strobes_after_resume", n_strobe - s0, 4);

    // Reset mid-block at cycle 20, then a full-scale block
    push_codes(500, 500, 500, 2);
    push_codes(1023, 1023, 1023, 4);
    do_reset();
    exp_strobe.push_back(8);
    exp_strobe.push_back(16);
    exp_strobe.push_back(29);
    exp_strobe.push_back(37);
    exp_strobe.push_back(45);
    exp_strobe.push_back(53);
    while (cyc < 20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("rst21");
    push_exp(1023, 1023, 1023, 1, 0, 56);
    drain(60);
    check("strobe_queue_left", exp_strobe.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sensor_sampler.md
# sensor_sampler

Sampling sequencer and averager that sits directly downstream of the three-channel sensor ADC stage. It generates the periodic `sensor_enable` strobe that drives the ADCs and captures the soil, DHT11 and rain digital codes one cycle later. It accumulates a block of samples per channel and publishes truncated averages with a one-cycle valid pulse. It also produces hysteresis-filtered `soil_dry` and `raining` flags for the irrigation controller.

## Interface
- `RESOLUTION`, 10: ADC code width, must equal the ADC stage width.
- `SAMPLE_DIV`, 1000: sample period in clock cycles; legal range ≥ 4.
- `AVG_LOG2`, 3: log2 of samples per average (N = 2^AVG_LOG2); legal range 0..6.
- `SOIL_DRY_ON`, 700: `soil_dry` sets when the soil average is ≥ this value.
- `SOIL_DRY_OFF`, 600: `soil_dry` clears when the soil average is ≤ this value; must be < `SOIL_DRY_ON`.
- `RAIN_ON`, 300: `raining` sets when the rain average is ≤ this value (wet sensor reads low).
- `RAIN_OFF`, 400: `raining` clears when the rain average is ≥ this value; must be > `RAIN_ON`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `run` in 1: sampling enable; low halts sampling and discards any partial block.
- `soil_digital` in RESOLUTION: registered code from the soil ADC.
- `dht11_digital` in RESOLUTION: registered code from the DHT11 ADC.
- `rain_digital` in RESOLUTION: registered code from the rain ADC.
- `sensor_enable` out 1: one-cycle conversion strobe to the ADC stage.
- `soil_avg` out RESOLUTION: latest soil average.
- `dht11_avg` out RESOLUTION: latest DHT11 average.
- `rain_avg` out RESOLUTION: latest rain average.
- `avg_valid` out 1: one-cycle pulse when new averages and flags are presented.
- `soil_dry` out 1: hysteresis flag, soil too dry.
- `raining` out 1: hysteresis flag, rain detected.

## Operation
- Free-running divider `div` counts 0..SAMPLE_DIV-1 and wraps. It counts regardless of `run`.
- FSM states are IDLE, ENABLE, CAPTURE and PUBLISH.
  - IDLE: go to ENABLE when `div == SAMPLE_DIV-1` and `run == 1`; otherwise stay in IDLE.
  - ENABLE (`div == 0`): `sensor_enable = 1` (combinational decode of the state, registered state only); next state is CAPTURE.
  - CAPTURE (`div == 1`): the ADC outputs were updated at the end of ENABLE. Add each input to its accumulator and increment `cnt`. If `cnt == N-1`, go to PUBLISH; otherwise go to IDLE.
  - PUBLISH (`div == 2`): register `acc >> AVG_LOG2` to each `*_avg`. Update the flags from the new averages, pulse `avg_valid`, clear the accumulators and `cnt`, then go to IDLE.
- Width rules:
  - Accumulator width is RESOLUTION+AVG_LOG2 per channel, so overflow cannot occur.
  - Averages are truncated (floor).
  - `cnt` width is max(AVG_LOG2,1).
- `soil_dry` next value: 1 if `soil_avg_new ≥ SOIL_DRY_ON`; 0 if `≤ SOIL_DRY_OFF`; otherwise hold.
- `raining` next value: 1 if `rain_avg_new ≤ RAIN_ON`; 0 if `≥ RAIN_OFF`; otherwise hold.
- `run` low: at the next edge the FSM goes to IDLE and the accumulators and `cnt` clear. Averages and flags hold their last values, and no `avg_valid` is issued.
  - If `run` falls during ENABLE, the ADC still converts but the sample is discarded.
  - If `run` falls during PUBLISH, PUBLISH completes; `run` low has no priority over PUBLISH.
- N = 1 (AVG_LOG2 = 0): every capture publishes.

## Timing
- Reset values: state IDLE, `div` 0, accumulators 0, `cnt` 0. All outputs are 0 (`sensor_enable`, averages, `avg_valid`, flags).
- Reset mid-block: all partial accumulation is lost, and the first strobe after reset is a fresh block.
- After reset is released with `run = 1`, the first `sensor_enable` occurs at cycle SAMPLE_DIV (cycle 0 being the first cycle with reset low). Subsequent strobes follow every SAMPLE_DIV cycles.
- `avg_valid` is high in the cycle with `div == 3` following the N-th capture. It is registered alongside the averages and flags, so all update on the same edge.
- The first `avg_valid` occurs at cycle N·SAMPLE_DIV + 3.

## Structure
- Shared package `sensor_pkg`:
  - FSM state enum `sampler_state_t`.
  - Default threshold constants.
  - Helper `function` for the hysteresis update.
- One natural sub-module: `sensor_accum`, one per channel (×3). It holds the per-channel accumulator, add/clear controls and shifted average output.
- The FSM and divider live in the top level.

## Test plan
All scenarios use SAMPLE_DIV = 8, AVG_LOG2 = 2 and default thresholds.
- Constant inputs soil = 512, dht11 = 300, rain = 1000 with `run` = 1 → `sensor_enable` pulses at cycles 8, 16, 24, 32. `avg_valid` is high only at cycle 35 with averages 512/300/1000, `soil_dry` = 0 and `raining` = 0.
- Soil codes 100, 101, 102, 103 on successive strobes → `soil_avg` = 101 (truncated from 101.5).
- Soil hysteresis with successive block averages 750, 650, 590, 650 → `soil_dry` goes 1, 1, 0, 0. Rain averages 250, 350, 420 → `raining` goes 1, 1, 0.
- `run` dropped after 2 captures and raised 20 cycles later → no `avg_valid` for the partial block. The next `avg_valid` arrives exactly 4 strobes after resume, with an average of only post-resume samples.
- Reset asserted for 1 cycle mid-block at cycle 20 → all outputs are 0 at cycle 21. The next strobe is at cycle 21 + 8 = 29.
- Maximum codes 1023 on all channels → averages are 1023 with no overflow, and `soil_dry` = 1.
